gc_response_rx: RTL and testbench
=================================

// Module: gc_response_rx
// PURPOSE
//  Receiver stage directly downstream of the controller command transmitter on the shared
//  GameCube data line. Once armed after a probe/poll command is sent, it decodes the
//  controller's pulse-width-coded reply (NumBits data bits plus one stop bit) into a
//  parallel word. It flags timeouts and framing faults so the controller FSM can retry.
// PARAMETERS
//  CLKS_PER_US       1    usClock cycles per microsecond; all timing thresholds scale by this
//  START_TIMEOUT_US  200  us of idle-high after Arm before declaring no-response
//  BIT_TIMEOUT_US    8    max high time between bits mid-frame
//  LOW_MAX_US        6    max legal low time of any bit; longer = framing error
// PORTS
//  usClock    in   1   system clock (1 MHz when CLKS_PER_US=1)
//  Reset      in   1   asynchronous, active-low reset
//  Arm        in   1   1-cycle pulse: start listening; latches NumBits
//  NumBits    in   7   expected data bits (24 probe, 64 poll); legal 1..64
//  Line       in   1   raw data-line level (tristate input side), asynchronous
//  Busy       out  1   high from Arm until RespValid/RespError
//  RespData   out  64  received bits, right-aligned, first bit received = MSB of field
//  RespValid  out  1   1-cycle pulse: frame complete and RespData stable
//  RespError  out  2   0 none,1 no start,2 bit timeout,3 framing; held until next Arm
//  BitCount   out  7   data bits received so far in current frame
// BEHAVIOUR
//  - Reset (async assert, sync deassert): state IDLE; Busy=0, RespData=0, RespValid=0,
//    RespError=0, BitCount=0; sync flops preset to 1 (idle-high line).
//  - Line passes through a 2-flop synchronizer; all decisions use the synced level and its
//    1-cycle-delayed copy. Fall = prev 1 & cur 0; rise = prev 0 & cur 1.
//  - THRESH = 2*CLKS_PER_US cycles. Low run < THRESH -> bit 1; >= THRESH -> bit 0.
//  - States:
//    IDLE: wait for Arm. On Arm: latch NumBits, clear RespData/BitCount/RespError,
//      Busy=1, timer=0 -> WAIT_START.
//    WAIT_START: on fall -> LOW (low_cnt=1). Timer reaches START_TIMEOUT_US*CLKS_PER_US
//      -> ERROR code 1. Line already low at Arm is not a fall; wait for high then fall.
//    LOW: low_cnt++ each cycle low. low_cnt > LOW_MAX_US*CLKS_PER_US -> ERROR code 3.
//      On rise: if BitCount<NumBits, shift bit in (RespData <= {RespData[62:0],bit}),
//      BitCount++, -> HIGH; else (stop bit) short -> DONE, long -> ERROR code 3.
//    HIGH: high_cnt++. On fall -> LOW (low_cnt=1, high_cnt=0).
//      high_cnt reaches BIT_TIMEOUT_US*CLKS_PER_US -> ERROR code 2.
//    DONE: RespValid=1 for exactly one cycle, Busy=0 -> IDLE.
//    ERROR: RespError set, Busy=0, RespValid stays 0 -> IDLE. RespData holds partial bits.
//  - Latency: RespValid asserts 1 cycle after the synced stop-bit rise (3 cycles after raw).
//  - Arm while Busy: abort current frame silently (no Valid/Error) and restart as IDLE+Arm.
//  - NumBits=0 or >64 is treated as 64.
//  - Counters 12 bits and saturate; they never wrap.
//  - Async Reset mid-frame: immediate return to reset values; the next frame needs a new Arm.
// STRUCTURE
//  - gc_pkg: rx_state_t enum, error-code localparams
//    (GC_ERR_NONE/NOSTART/BITTO/FRAME), GC_PROBE_BITS=24, GC_POLL_BITS=64,
//    gc_status_t struct plus unpack function mapping the 64-bit poll reply to buttons,
//    sticks and triggers.
//  - One sub-module: gc_line_sync (2-flop synchronizer + edge detect, async active-low reset).
//  - Main FSM and datapath live in this file; no decode of buttons here.
// TESTING  (CLKS_PER_US=1; bit0 = 3 low/1 high, bit1 = 1 low/3 high)
//  - Arm, NumBits=24, drive 0x090000 + stop -> RespValid 1 cycle, RespData=0x090000,
//    RespError=0, BitCount=24.
//  - Arm, NumBits=64, drive 0x0080_8080_8080_1F1F + stop -> RespData equals that value,
//    Busy falls with RespValid.
//  - Arm, line held high 200 cycles -> RespError=1 at cycle 200, no RespValid, Busy=0.
//  - Arm, 10 good bits then line high 8 cycles -> RespError=2, BitCount=10.
//  - Arm, low pulse of 7 cycles -> RespError=3. Separately, stop bit low 3 -> RespError=3.
//  - Assert Reset mid-frame at bit 30 -> all outputs 0 immediately; a new Arm plus a full
//    24-bit frame decodes correctly.
//  - Re-Arm at bit 12 -> no pulse from aborted frame; the next full frame is valid.

Source files
------------

// File: rtl/gc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gc_pkg
// Description : Shared types and constants for the GameCube controller link.
//               Holds the receiver state encoding, response error codes,
//               standard reply lengths, the decoded poll-reply layout and a
//               saturating counter helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package gc_pkg;

  typedef enum logic [2:0] {
    RX_IDLE       = 3'd0,
    RX_WAIT_START = 3'd1,
    RX_LOW        = 3'd2,
    RX_HIGH       = 3'd3,
    RX_DONE       = 3'd4,
    RX_ERROR      = 3'd5
  } rx_state_t;

  localparam logic [1:0] GC_ERR_NONE    = 2'd0;
  localparam logic [1:0] GC_ERR_NOSTART = 2'd1;
  localparam logic [1:0] GC_ERR_BITTO   = 2'd2;
  localparam logic [1:0] GC_ERR_FRAME   = 2'd3;

  localparam logic [6:0] GC_PROBE_BITS = 7'd24;
  localparam logic [6:0] GC_POLL_BITS  = 7'd64;

  typedef struct packed {
    logic       start;
    logic       btn_y;
    logic       btn_x;
    logic       btn_b;
    logic       btn_a;
    logic       btn_l;
    logic       btn_r;
    logic       btn_z;
    logic       dpad_up;
    logic       dpad_down;
    logic       dpad_right;
    logic       dpad_left;
    logic [7:0] stick_x;
    logic [7:0] stick_y;
    logic [7:0] cstick_x;
    logic [7:0] cstick_y;
    logic [7:0] trig_l;
    logic [7:0] trig_r;
  } gc_status_t;

  // Poll reply: byte0 = 0,0,0,Start,Y,X,B,A ; byte1 = 1,L,R,Z,Up,Down,Right,Left ;
  // then stick X/Y, C-stick X/Y, analog L, analog R.
  function automatic gc_status_t gc_unpack_status(input logic [63:0] raw);
    gc_status_t s;
    s.start      = raw[60];
    s.btn_y      = raw[59];
    s.btn_x      = raw[58];
    s.btn_b      = raw[57];
    s.btn_a      = raw[56];
    s.btn_l      = raw[54];
    s.btn_r      = raw[53];
    s.btn_z      = raw[52];
    s.dpad_up    = raw[51];
    s.dpad_down  = raw[50];
    s.dpad_right = raw[49];
    s.dpad_left  = raw[48];
    s.stick_x    = raw[47:40];
    s.stick_y    = raw[39:32];
    s.cstick_x   = raw[31:24];
    s.cstick_y   = raw[23:16];
    s.trig_l     = raw[15:8];
    s.trig_r     = raw[7:0];
    return s;
  endfunction

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [11:0] gc_sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gc_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : gc_line_sync
// Description : Two-flop synchronizer for the asynchronous data line plus a
//               delayed copy for edge detection. All flops preset to 1 so an
//               idle-high line never produces a spurious edge out of reset.
// Ports       : usClock (in)  system clock
//               Reset   (in)  asynchronous active-low reset
//               Line    (in)  raw data-line level
//               Fall    (out) synced level went 1 -> 0 this cycle
//               Rise    (out) synced level went 0 -> 1 this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module gc_line_sync (
  input  logic usClock,
  input  logic Reset,
  input  logic Line,
  output logic Fall,
  output logic Rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge usClock or negedge Reset) begin
    if (!Reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= Line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign Fall =  r_prev & ~r_sync;
  assign Rise = ~r_prev &  r_sync;

endmodule
`default_nettype wire

// File: rtl/gc_response_rx.sv
`default_nettype none
// ============================================================================
// Module      : gc_response_rx
// Description : Decodes the controller's pulse-width-coded reply (NumBits
//               data bits + stop bit) into a right-aligned parallel word and
//               reports no-start, bit-timeout and framing faults.
// Ports       : usClock   (in)  system clock
//               Reset     (in)  asynchronous active-low reset
//               Arm       (in)  1-cycle start pulse, latches NumBits
//               NumBits   (in)  expected data bits, 0 or >64 means 64
//               Line      (in)  raw data-line level
//               Busy      (out) frame in progress
//               RespData  (out) received bits, first bit = MSB of field
//               RespValid (out) 1-cycle frame-complete pulse
//               RespError (out) error code, held until next Arm
//               BitCount  (out) data bits received so far
// Revision    : 1.0 - initial release
// ============================================================================
module gc_response_rx
  import gc_pkg::*;
#(
  parameter int unsigned CLKS_PER_US      = 1,
  parameter int unsigned START_TIMEOUT_US = 200,
  parameter int unsigned BIT_TIMEOUT_US   = 8,
  parameter int unsigned LOW_MAX_US       = 6
) (
  input  logic        usClock,
  input  logic        Reset,
  input  logic        Arm,
  input  logic [6:0]  NumBits,
  input  logic        Line,
  output logic        Busy,
  output logic [63:0] RespData,
  output logic        RespValid,
  output logic [1:0]  RespError,
  output logic [6:0]  BitCount
);

  localparam logic [11:0] c_start_lim = 12'(START_TIMEOUT_US * CLKS_PER_US);
  localparam logic [11:0] c_bit_lim   = 12'(BIT_TIMEOUT_US * CLKS_PER_US);
  localparam logic [11:0] c_low_max   = 12'(LOW_MAX_US * CLKS_PER_US);
  localparam logic [11:0] c_thresh    = 12'(2 * CLKS_PER_US);

  logic w_fall;
  logic w_rise;

  gc_line_sync u_line_sync (
    .usClock (usClock),
    .Reset   (Reset),
    .Line    (Line),
    .Fall    (w_fall),
    .Rise    (w_rise)
  );

  rx_state_t   r_state, w_state_nxt;
  // One counter serves as start timer, low-run and high-run counter; the
  // states using them are mutually exclusive.
  logic [11:0] r_cnt, w_cnt_nxt;
  logic [6:0]  r_num_bits, w_num_bits_nxt;
  logic [63:0] r_data, w_data_nxt;
  logic [6:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [1:0]  r_err, w_err_nxt;
  logic        r_busy, r_valid;
  logic [11:0] w_inc;
  logic        w_bit;

  assign w_inc = gc_sat_inc(r_cnt);
  assign w_bit = (r_cnt < c_thresh);   // short low run encodes a 1

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_num_bits_nxt = r_num_bits;
    w_data_nxt     = r_data;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_err_nxt      = r_err;

    if (Arm) begin
      // Arm in any state restarts cleanly; an aborted frame reports nothing.
      w_num_bits_nxt = (NumBits == 7'd0 || NumBits > 7'd64) ? 7'd64 : NumBits;
      w_data_nxt     = '0;
      w_bit_cnt_nxt  = '0;
      w_err_nxt      = GC_ERR_NONE;
      w_cnt_nxt      = '0;
      w_state_nxt    = RX_WAIT_START;
    end else begin
      case (r_state)
        RX_IDLE: ;
        RX_WAIT_START: begin
          if (w_fall) begin
            w_state_nxt = RX_LOW;
            w_cnt_nxt   = 12'd1;
          end else if (w_inc >= c_start_lim) begin
            w_state_nxt = RX_ERROR;
            w_err_nxt   = GC_ERR_NOSTART;
          end else begin
            w_cnt_nxt = w_inc;
          end
        end
        RX_LOW: begin
          if (w_rise) begin
            if (r_bit_cnt < r_num_bits) begin
              w_data_nxt    = {r_data[62:0], w_bit};
              w_bit_cnt_nxt = r_bit_cnt + 7'd1;
              w_cnt_nxt     = '0;
              w_state_nxt   = RX_HIGH;
            end else if (w_bit) begin
              w_state_nxt = RX_DONE;     // short stop bit
            end else begin
              w_state_nxt = RX_ERROR;
              w_err_nxt   = GC_ERR_FRAME;
            end
          end else if (w_inc > c_low_max) begin
            w_state_nxt = RX_ERROR;
            w_err_nxt   = GC_ERR_FRAME;
          end else begin
            w_cnt_nxt = w_inc;
          end
        end
        RX_HIGH: begin
          if (w_fall) begin
            w_state_nxt = RX_LOW;
            w_cnt_nxt   = 12'd1;
          end else if (w_inc >= c_bit_lim) begin
            w_state_nxt = RX_ERROR;
            w_err_nxt   = GC_ERR_BITTO;
          end else begin
            w_cnt_nxt = w_inc;
          end
        end
        RX_DONE:  w_state_nxt = RX_IDLE;
        RX_ERROR: w_state_nxt = RX_IDLE;
        default:  w_state_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge usClock or negedge Reset) begin
    if (!Reset) begin
      r_state    <= RX_IDLE;
      r_cnt      <= '0;
      r_num_bits <= GC_POLL_BITS;
      r_data     <= '0;
      r_bit_cnt  <= '0;
      r_err      <= GC_ERR_NONE;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_num_bits <= w_num_bits_nxt;
      r_data     <= w_data_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_err      <= w_err_nxt;
      // Busy drops on the same edge that raises Valid or Error.
      r_busy     <= (w_state_nxt == RX_WAIT_START) || (w_state_nxt == RX_LOW) ||
                    (w_state_nxt == RX_HIGH);
      r_valid    <= (w_state_nxt == RX_DONE);
    end
  end

  assign Busy      = r_busy;
  assign RespData  = r_data;
  assign RespValid = r_valid;
  assign RespError = r_err;
  assign BitCount  = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gc_response_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_gc_response_rx
// Description : Self-checking bench for gc_response_rx. Frames are built from
//               low/high pulse durations; expected words and error codes are
//               derived from the pulse-width rules directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gc_response_rx;

  logic        usClock = 1'b0;
  logic        Reset;
  logic        Arm;
  logic [6:0]  NumBits;
  logic        Line;
  logic        Busy;
  logic [63:0] RespData;
  logic        RespValid;
  logic [1:0]  RespError;
  logic [6:0]  BitCount;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;

  gc_response_rx dut (
    .usClock   (usClock),
    .Reset     (Reset),
    .Arm       (Arm),
    .NumBits   (NumBits),
    .Line      (Line),
    .Busy      (Busy),
    .RespData  (RespData),
    .RespValid (RespValid),
    .RespError (RespError),
    .BitCount  (BitCount)
  );

  always #5 usClock = ~usClock;

  always @(negedge usClock) if (RespValid === 1'b1) valid_cnt++;

  task automatic step();
    @(posedge usClock);
    #1;
  endtask

  task automatic send_pulse(input int lo, input int hi);
    Line = 1'b0;
    repeat (lo) step();
    Line = 1'b1;
    repeat (hi) step();
  endtask

  // MSB first, spec encoding: 0 = 3 low / 1 high, 1 = 1 low / 3 high
  task automatic send_word(input logic [63:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) send_pulse(d[i] ? 1 : 3, d[i] ? 3 : 1);
  endtask

  task automatic arm(input logic [6:0] n);
    Arm = 1'b1;
    NumBits = n;
    step();
    Arm = 1'b0;
  endtask

  // Short stop bit: line low one cycle, then left high.
  task automatic send_stop();
    Line = 1'b0;
    step();
    Line = 1'b1;
  endtask

  task automatic wait_result(input int budget, output int cyc, output bit got,
                             output logic prev_busy, output logic busy_at);
    got = 1'b0;
    cyc = 0;
    prev_busy = Busy;
    busy_at = Busy;
    while (!got && cyc < budget) begin
      prev_busy = Busy;
      step();
      cyc++;
      if (RespValid === 1'b1 || RespError !== 2'd0) begin
        got = 1'b1;
        busy_at = Busy;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; Arm = 1'b0; NumBits = 7'd0; Line = 1'b1;
    step(); step();
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    tests++; if (RespData !== 64'd0) begin fails++; $display("FAIL reset_data: got %h expected 0", RespData); end
    tests++; if (RespValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", RespValid); end
    tests++; if (RespError !== 2'd0) begin fails++; $display("FAIL reset_error: got %0d expected 0", RespError); end
    tests++; if (BitCount !== 7'd0) begin fails++; $display("FAIL reset_bitcount: got %0d expected 0", BitCount); end
    Reset = 1'b1;
    step(); step();
  endtask

  task automatic test_probe();
    int cyc; bit got; logic pb, ba; int v0;
    v0 = valid_cnt;
    arm(7'd24);
    tests++; if (Busy !== 1'b1) begin fails++; $display("FAIL probe_busy_armed: got %b expected 1", Busy); end
    send_word(64'h090000, 24);
    send_stop();
    wait_result(20, cyc, got, pb, ba);
    tests++; if (!got || RespValid !== 1'b1 || cyc != 3) begin
      fails++; $display("FAIL probe_latency: got valid=%b after %0d cycles expected valid after 3", RespValid, cyc); end
    tests++; if (RespData !== 64'h090000) begin fails++; $display("FAIL probe_data: got %h expected 090000", RespData); end
    tests++; if (RespError !== 2'd0) begin fails++; $display("FAIL probe_error: got %0d expected 0", RespError); end
    tests++; if (BitCount !== 7'd24) begin fails++; $display("FAIL probe_bitcount: got %0d expected 24", BitCount); end
    step();
    tests++; if (RespValid !== 1'b0 || valid_cnt - v0 != 1) begin
      fails++; $display("FAIL probe_pulse_width: got valid=%b pulses=%0d expected 0 and 1", RespValid, valid_cnt - v0); end
  endtask

  task automatic test_poll();
    int cyc; bit got; logic pb, ba;
    logic [63:0] exp;
    exp = 64'h0080_8080_8080_1F1F;
    arm(7'd64);
    send_word(exp, 64);
    send_stop();
    wait_result(20, cyc, got, pb, ba);
    tests++; if (!got || RespData !== exp) begin fails++; $display("FAIL poll_data: got %h expected %h", RespData, exp); end
    tests++; if (ba !== 1'b0 || pb !== 1'b1) begin
      fails++; $display("FAIL poll_busy_fall: got busy %b->%b expected 1->0 with valid", pb, ba); end
    step();
  endtask

  task automatic test_random();
    int cyc; bit got; logic pb, ba; int v0;
    int neff; logic [6:0] n; logic [63:0] exp; int lo;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) n = 7'd0;
      else if (k == 1) n = 7'd100;
      else n = 7'($urandom_range(1, 64));
      neff = (n == 0 || n > 64) ? 64 : int'(n);
      v0 = valid_cnt;
      exp = 64'd0;
      arm(n);
      repeat ($urandom_range(0, 20)) step();
      for (int i = 0; i < neff; i++) begin
        lo = ($urandom_range(0, 1) == 1) ? 1 : int'($urandom_range(2, 6));
        exp = (exp << 1) | ((lo < 2) ? 64'd1 : 64'd0);
        send_pulse(lo, int'($urandom_range(1, 3)));
      end
      send_stop();
      wait_result(20, cyc, got, pb, ba);
      tests++; if (!got || RespValid !== 1'b1 || RespData !== exp) begin
        fails++; $display("FAIL random_data[%0d]: got %h valid=%b expected %h", k, RespData, RespValid, exp); end
      tests++; if (BitCount !== 7'(neff) || RespError !== 2'd0) begin
        fails++; $display("FAIL random_status[%0d]: got count=%0d err=%0d expected %0d and 0", k, BitCount, RespError, neff); end
      step();
      tests++; if (valid_cnt - v0 != 1) begin
        fails++; $display("FAIL random_pulses[%0d]: got %0d expected 1", k, valid_cnt - v0); end
    end
  endtask

  task automatic test_no_start();
    int cyc; bit got; logic pb, ba; int v0;
    v0 = valid_cnt;
    Line = 1'b1;
    arm(7'd24);
    wait_result(300, cyc, got, pb, ba);
    tests++; if (!got || RespError !== 2'd1 || cyc != 200) begin
      fails++; $display("FAIL nostart: got err=%0d at cycle %0d expected 1 at 200", RespError, cyc); end
    tests++; if (ba !== 1'b0 || valid_cnt != v0) begin
      fails++; $display("FAIL nostart_flags: got busy=%b pulses=%0d expected 0 and 0", ba, valid_cnt - v0); end
    step();
  endtask

  task automatic test_bit_timeout();
    int cyc; bit got; logic pb, ba; int v0;
    logic [63:0] d;
    d = {32'($urandom), 32'($urandom)};
    v0 = valid_cnt;
    arm(7'd64);
    send_word(d, 10);
    wait_result(40, cyc, got, pb, ba);
    tests++; if (!got || RespError !== 2'd2) begin fails++; $display("FAIL bitto_error: got %0d expected 2", RespError); end
    tests++; if (BitCount !== 7'd10 || RespData !== {54'd0, d[9:0]}) begin
      fails++; $display("FAIL bitto_partial: got count=%0d data=%h expected 10 and %h", BitCount, RespData, {54'd0, d[9:0]}); end
    tests++; if (valid_cnt != v0 || Busy !== 1'b0) begin
      fails++; $display("FAIL bitto_flags: got pulses=%0d busy=%b expected 0 and 0", valid_cnt - v0, Busy); end
    step();
  endtask

  task automatic test_framing();
    int cyc; bit got; logic pb, ba; int v0;
    logic [63:0] d;
    v0 = valid_cnt;
    arm(7'd24);
    Line = 1'b0;
    wait_result(20, cyc, got, pb, ba);
    tests++; if (!got || RespError !== 2'd3) begin fails++; $display("FAIL frame_longlow: got %0d expected 3", RespError); end
    Line = 1'b1;
    repeat (4) step();
    d = {32'd0, 32'($urandom)};
    arm(7'd24);
    send_word(d, 24);
    send_pulse(3, 0);
    wait_result(20, cyc, got, pb, ba);
    tests++; if (!got || RespError !== 2'd3) begin fails++; $display("FAIL frame_longstop: got %0d expected 3", RespError); end
    tests++; if (RespData !== {40'd0, d[23:0]} || valid_cnt != v0) begin
      fails++; $display("FAIL frame_flags: got data=%h pulses=%0d expected %h and 0", RespData, valid_cnt - v0, {40'd0, d[23:0]}); end
    step();
  endtask

  task automatic test_reset_mid();
    int cyc; bit got; logic pb, ba; int v0;
    logic [63:0] d;
    d = {32'($urandom), 32'($urandom)} | 64'h1;
    arm(7'd64);
    send_word(d, 30);
    Line = 1'b0;
    step();
    Reset = 1'b0;
    #1;
    tests++; if ({Busy, RespValid, RespError, BitCount} !== 11'd0 || RespData !== 64'd0) begin
      fails++; $display("FAIL resetmid_clear: got busy=%b valid=%b err=%0d count=%0d data=%h expected all 0",
                        Busy, RespValid, RespError, BitCount, RespData); end
    Line = 1'b1;
    step(); step();
    Reset = 1'b1;
    step();
    v0 = valid_cnt;
    d = {32'd0, 32'($urandom)};
    arm(7'd24);
    send_word(d, 24);
    send_stop();
    wait_result(20, cyc, got, pb, ba);
    tests++; if (!got || RespValid !== 1'b1 || RespData !== {40'd0, d[23:0]}) begin
      fails++; $display("FAIL resetmid_next: got %h valid=%b expected %h", RespData, RespValid, {40'd0, d[23:0]}); end
    step();
    tests++; if (valid_cnt - v0 != 1) begin fails++; $display("FAIL resetmid_pulses: got %0d expected 1", valid_cnt - v0); end
  endtask

  task automatic test_rearm();
    int cyc; bit got; logic pb, ba; int v0;
    logic [63:0] d1, d2;
    d1 = {32'd0, 32'($urandom)};
    d2 = {32'd0, 32'($urandom)};
    v0 = valid_cnt;
    arm(7'd24);
    send_word(d1, 12);
    arm(7'd24);
    tests++; if (BitCount !== 7'd0 || RespError !== 2'd0 || Busy !== 1'b1) begin
      fails++; $display("FAIL rearm_restart: got count=%0d err=%0d busy=%b expected 0,0,1", BitCount, RespError, Busy); end
    send_word(d2, 24);
    send_stop();
    wait_result(20, cyc, got, pb, ba);
    tests++; if (!got || RespValid !== 1'b1 || RespData !== {40'd0, d2[23:0]} || RespError !== 2'd0) begin
      fails++; $display("FAIL rearm_data: got %h valid=%b err=%0d expected %h", RespData, RespValid, RespError, {40'd0, d2[23:0]}); end
    step();
    tests++; if (valid_cnt - v0 != 1) begin fails++; $display("FAIL rearm_pulses: got %0d expected 1", valid_cnt - v0); end
  endtask

  initial begin
    test_reset();
    test_probe();
    test_poll();
    test_random();
    test_no_start();
    test_bit_timeout();
    test_framing();
    test_reset_mid();
    test_rearm();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
